// File: rtl/fcs_pkg.sv
// Shared CRC-32 constants, lane state encoding and byte-wise CRC update for the FCS checkers.
package fcs_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    FCS
  } lane_state_e;

  // Reflected CRC-32 over one byte, LSB first; the loop unrolls into 8 XOR stages.
  function automatic logic [31:0] crc32_update_byte(input logic [31:0] crc,
                                                    input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/fcs_lane.sv
// One byte-wide Ethernet FCS checker lane: CRC, length counter and frame FSM.
module fcs_lane
  import fcs_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 2)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_valid,
  input  logic       start_of_frame,
  input  logic       end_of_frame,
  input  logic [7:0] data_in,
  output logic       fcs_done,
  output logic       fcs_error,
  output logic       len_error
);

  localparam logic [LEN_W-1:0] LenSat = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LenMin = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LenMax = LEN_W'(MAX_LEN);

  lane_state_e      state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       fcs_cnt_q, fcs_cnt_d;
  logic             done_q, done_d;
  logic             fcs_err_q, fcs_err_d;
  logic             len_err_q, len_err_d;

  logic [31:0]      crc_next;
  logic [31:0]      crc_first;
  logic [LEN_W-1:0] len_inc;

  assign crc_next  = crc32_update_byte(crc_q, data_in);
  assign crc_first = crc32_update_byte(CRC32_INIT, data_in);
  // Saturate so oversize frames can never wrap back into the legal range.
  assign len_inc   = (len_q == LenSat) ? len_q : len_q + LEN_W'(1);

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    fcs_cnt_d = fcs_cnt_q;
    done_d    = 1'b0;
    fcs_err_d = fcs_err_q;
    len_err_d = len_err_q;

    if (data_valid) begin
      if (start_of_frame) begin
        // Also aborts any frame in flight, with no result reported for it.
        crc_d     = crc_first;
        len_d     = LEN_W'(1);
        fcs_cnt_d = 2'd1;
        state_d   = end_of_frame ? FCS : DATA;
      end else begin
        unique case (state_q)
          IDLE: ;
          DATA: begin
            crc_d = crc_next;
            len_d = len_inc;
            if (end_of_frame) begin
              fcs_cnt_d = 2'd1;
              state_d   = FCS;
            end
          end
          FCS: begin
            crc_d = crc_next;
            len_d = len_inc;
            if (fcs_cnt_q == 2'd3) begin
              state_d   = IDLE;
              done_d    = 1'b1;
              fcs_err_d = (crc_next != CRC32_RESIDUE);
              len_err_d = (len_inc < LenMin) || (len_inc > LenMax);
            end else begin
              fcs_cnt_d = fcs_cnt_q + 2'd1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      crc_q     <= CRC32_INIT;
      len_q     <= '0;
      fcs_cnt_q <= 2'd0;
      done_q    <= 1'b0;
      fcs_err_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      fcs_cnt_q <= fcs_cnt_d;
      done_q    <= done_d;
      fcs_err_q <= fcs_err_d;
      len_err_q <= len_err_d;
    end
  end

  assign fcs_done  = done_q;
  assign fcs_error = fcs_err_q;
  assign len_error = len_err_q;

endmodule

// File: rtl/fcs_check_multi.sv
// NUM_PORTS independent FCS checker lanes, one per switch ingress port.
module fcs_check_multi
  import fcs_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned MIN_LEN   = 64,
  parameter int unsigned MAX_LEN   = 1518,
  parameter int unsigned LEN_W     = $clog2(MAX_LEN + 2)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PORTS-1:0]   data_valid,
  input  logic [NUM_PORTS-1:0]   start_of_frame,
  input  logic [NUM_PORTS-1:0]   end_of_frame,
  input  logic [8*NUM_PORTS-1:0] data_in,
  output logic [NUM_PORTS-1:0]   fcs_done,
  output logic [NUM_PORTS-1:0]   fcs_error,
  output logic [NUM_PORTS-1:0]   len_error
);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    fcs_lane #(
      .MIN_LEN(MIN_LEN),
      .MAX_LEN(MAX_LEN),
      .LEN_W  (LEN_W)
    ) u_lane (
      .clk           (clk),
      .reset         (reset),
      .data_valid    (data_valid[i]),
      .start_of_frame(start_of_frame[i]),
      .end_of_frame  (end_of_frame[i]),
      .data_in       (data_in[8*i +: 8]),
      .fcs_done      (fcs_done[i]),
      .fcs_error     (fcs_error[i]),
      .len_error     (len_error[i])
    );
  end

endmodule
